// File: rtl/uart_img_pkg.sv
// Shared types for the image-burst path between the UART packet classifier
// and the colour-plane SRAMs.
package uart_img_pkg;

  localparam int PKT_BYTES    = 12;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [2:0] {IDLE, ARMED, COLLECT, WRITE, DONE} seq_state_e;
  typedef enum logic [1:0] {CH_R, CH_B, CH_G} channel_e;

  typedef struct packed {
    logic [1:0] pix;
    channel_e   ch;
  } lane_sel_t;

  // Payload byte k carries channel k mod 3 of pixel k / 3.
  function automatic lane_sel_t lane_of(input logic [3:0] idx);
    lane_sel_t sel;
    sel.pix = 2'(idx / 4'd3);
    sel.ch  = channel_e'(2'(idx % 4'd3));
    return sel;
  endfunction

endpackage

// File: rtl/burst_pixel_packer.sv
// Byte-index counter and the three per-plane 32-bit lane registers that
// assemble one 4-pixel packet.
module burst_pixel_packer #(
  parameter int PKT_BYTES = 12
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_take,
  input  logic        i_sof,
  input  logic [7:0]  i_data,
  output logic        count_eq_11,
  output logic        count_eq_12,
  output logic        overflow,
  output logic [31:0] word_r,
  output logic [31:0] word_g,
  output logic [31:0] word_b
);
  import uart_img_pkg::*;

  localparam int IDX_W = $clog2(PKT_BYTES + 1);

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] wr_idx;
  lane_sel_t        sel;

  // A start-of-packet byte always lands in slot 0, whatever the old index was.
  assign wr_idx      = i_sof ? '0 : idx;
  assign sel         = lane_of(4'(wr_idx));
  assign count_eq_11 = (idx == IDX_W'(PKT_BYTES - 1));
  assign count_eq_12 = (idx == IDX_W'(PKT_BYTES));
  assign overflow    = i_take && !i_sof && count_eq_12;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the lane registers are only 96 flops, so they are reset along with
  // the index; larger buffers would be left unreset and qualified instead.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx    <= '0;
      word_r <= '0;
      word_g <= '0;
      word_b <= '0;
    end else if (i_clr) begin
      idx <= '0;
    end else if (i_take && !overflow) begin
      idx <= wr_idx + IDX_W'(1);
      case (sel.ch)
        CH_R:    word_r[{sel.pix, 3'b000} +: 8] <= i_data;
        CH_B:    word_b[{sel.pix, 3'b000} +: 8] <= i_data;
        CH_G:    word_g[{sel.pix, 3'b000} +: 8] <= i_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/burst_pixel_sequencer.sv
// Collects 12-byte pixel packets after a burst command and writes one packed
// word per packet to the red, green and blue SRAMs at a shared address.
module burst_pixel_sequencer #(
  parameter int DIM_W     = 12,
  parameter int ADDR_W    = 16,
  parameter int PKT_BYTES = 12
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_start,
  input  logic [DIM_W-1:0]  i_cfg_height,
  input  logic [DIM_W-1:0]  i_cfg_width,
  input  logic              i_abort,
  input  logic              i_pkt_sof,
  input  logic              i_pkt_eof,
  input  logic              i_px_valid,
  input  logic [7:0]        i_px_data,
  output logic              o_px_ready,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [31:0]       o_sram_wdata_r,
  output logic [31:0]       o_sram_wdata_g,
  output logic [31:0]       o_sram_wdata_b,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_word_cnt
);
  import uart_img_pkg::*;

  localparam int PROD_W = 2 * DIM_W;

  seq_state_e        state, state_nxt;
  logic [ADDR_W:0]   total_words;
  logic [PROD_W-1:0] prod, cfg_words;
  logic              cfg_bad, byte_in, eof_full;
  logic              pk_take, pk_clr, set_err;
  logic              pk_eq_11, pk_eq_12, pk_overflow;

  assign prod      = PROD_W'(i_cfg_height) * PROD_W'(i_cfg_width);
  assign cfg_words = (prod + PROD_W'(PIX_PER_WORD - 1)) / PROD_W'(PIX_PER_WORD);
  assign cfg_bad   = (i_cfg_height == '0) || (i_cfg_width == '0) ||
                     (64'(cfg_words) > (64'd1 << ADDR_W));

  assign byte_in = i_px_valid && (state == ARMED || state == COLLECT);
  assign pk_take = byte_in && (state == COLLECT || i_pkt_sof);
  // A byte arriving with the eof is counted before the eof is judged.
  assign eof_full = byte_in ? (!i_pkt_sof && pk_eq_11) : pk_eq_12;

  burst_pixel_packer #(.PKT_BYTES(PKT_BYTES)) u_packer (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (pk_clr),
    .i_take      (pk_take),
    .i_sof       (i_pkt_sof),
    .i_data      (i_px_data),
    .count_eq_11 (pk_eq_11),
    .count_eq_12 (pk_eq_12),
    .overflow    (pk_overflow),
    .word_r      (o_sram_wdata_r),
    .word_g      (o_sram_wdata_g),
    .word_b      (o_sram_wdata_b)
  );

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    pk_clr    = 1'b0;
    if (i_cfg_start) begin
      pk_clr    = 1'b1;
      state_nxt = cfg_bad ? IDLE : ARMED;
    end else if (i_abort) begin
      pk_clr    = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        ARMED: begin
          if (byte_in && !i_pkt_sof) begin
            set_err = 1'b1;
          end else if (byte_in) begin
            state_nxt = COLLECT;
            if (i_pkt_eof) begin
              set_err   = 1'b1;
              pk_clr    = 1'b1;
              state_nxt = ARMED;
            end
          end
        end
        COLLECT: begin
          if (byte_in && i_pkt_sof) set_err = 1'b1;
          if (pk_overflow) begin
            set_err   = 1'b1;
            pk_clr    = 1'b1;
            state_nxt = ARMED;
          end else if (i_pkt_eof) begin
            if (eof_full) begin
              state_nxt = WRITE;
            end else begin
              set_err   = 1'b1;
              pk_clr    = 1'b1;
              state_nxt = ARMED;
            end
          end
        end
        WRITE:   state_nxt = ((o_word_cnt + (ADDR_W+1)'(1)) == total_words) ? DONE : ARMED;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_sram_we   <= 1'b0;
      o_px_ready  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_sram_addr <= '0;
      o_word_cnt  <= '0;
      total_words <= '0;
    end else begin
      state      <= state_nxt;
      o_sram_we  <= (state_nxt == WRITE);
      o_px_ready <= (state_nxt == ARMED) || (state_nxt == COLLECT);
      o_busy     <= (state_nxt == ARMED) || (state_nxt == COLLECT) || (state_nxt == WRITE);
      o_done     <= (state_nxt == DONE);
      if (i_cfg_start) begin
        o_err       <= cfg_bad;
        o_sram_addr <= '0;
        o_word_cnt  <= '0;
        total_words <= (ADDR_W+1)'(cfg_words);
      end else begin
        if (set_err) o_err <= 1'b1;
        // The write strobe has already been presented, so the word counts
        // even if an abort lands on this cycle.
        if (state == WRITE) begin
          o_sram_addr <= o_sram_addr + ADDR_W'(1);
          o_word_cnt  <= o_word_cnt + (ADDR_W+1)'(1);
        end
      end
    end
  end

endmodule

// File: doc/burst_pixel_sequencer.md
Name: burst_pixel_sequencer

Overview:
Sequences image-burst payload into the three colour-plane SRAMs. After a burst-start command (height/width) from the command classifier, it collects 12-byte pixel packets (4 pixels in R,B,G byte order), packs each plane into one 32-bit word and issues a single-cycle write to the red, green and blue SRAMs at a shared, auto-incrementing word address. It tracks the image size, signals completion and flags malformed packets. It sits between the UART packet classifier and the u_sram_red/green/blue instances inside uart_top.

Parameters:
DIM_W, 12, width of the height and width fields
ADDR_W, 16, SRAM word-address width
PKT_BYTES, 12, payload bytes per burst packet (fixed: 4 pixels x 3 channels)

Ports:
clk  in  1  system clock (176 MHz)
i_rst_n  in  1  asynchronous active-low reset
i_cfg_start  in  1  one-cycle pulse: burst command accepted; latch height and width
i_cfg_height  in  DIM_W  image height in pixels
i_cfg_width  in  DIM_W  image width in pixels
i_abort  in  1  one-cycle pulse: cancel the burst and return to IDLE
i_pkt_sof  in  1  qualifies the first payload byte of a packet (with i_px_valid)
i_pkt_eof  in  1  one-cycle pulse: closing delimiter seen; no data
i_px_valid  in  1  payload byte valid; delimiters are already stripped
i_px_data  in  8  payload byte
o_px_ready  out  1  byte accepted when i_px_valid and o_px_ready
o_sram_we  out  1  write strobe, common to all three planes
o_sram_addr  out  ADDR_W  word address
o_sram_wdata_r  out  32  red word {P3,P2,P1,P0}
o_sram_wdata_g  out  32  green word
o_sram_wdata_b  out  32  blue word
o_busy  out  1  high while ARMED, COLLECT or WRITE
o_done  out  1  sticky: all words written; cleared by the next i_cfg_start
o_err  out  1  sticky: bad config or malformed packet; cleared by the next i_cfg_start
o_word_cnt  out  ADDR_W+1  words written so far

Behaviour:
- Reset: state IDLE; all outputs 0; the byte index, pixel buffers, address and counters are cleared.
- i_cfg_start (honoured in any state) clears o_done, o_err, the address and o_word_cnt.
  - Computes total_words = ceil(H*W/4) as a 2*DIM_W-bit product followed by (prod+3)>>2.
  - If H==0, W==0 or total_words > 2**ADDR_W: set o_err and go to IDLE.
  - Otherwise go to ARMED.
- States:
  - IDLE: o_px_ready=0.
  - ARMED: o_px_ready=1. A byte with i_pkt_sof stores as index 0 and moves to COLLECT. Bytes without sof are dropped and set o_err (state unchanged).
  - COLLECT: o_px_ready=1. Byte k (k=0..11) goes to channel k mod 3 (0=R, 1=B, 2=G) of pixel k/3, i.e. byte lane [8*(k/3)+:8] of that plane.
    - An i_pkt_eof after exactly 12 bytes moves to WRITE.
    - An eof with fewer than 12 bytes, or a 13th byte, sets o_err, discards the packet and returns to ARMED; the address does not advance.
    - An sof inside COLLECT restarts the packet at index 0 and sets o_err.
  - WRITE: exactly one cycle. o_sram_we=1, address and data registered outputs, o_px_ready=0. Next cycle the address increments and o_word_cnt increments. If o_word_cnt then equals total_words, go to DONE; otherwise go to ARMED.
  - DONE: o_done=1, o_px_ready=0. Extra packets are ignored (no o_err). Leaves only on i_cfg_start.
- Latency: o_sram_we asserts on the cycle after the eof is sampled.
- A final partial word (H*W not a multiple of 4) still requires a full 12-byte packet; all 4 lanes are written.
- i_abort in any state returns to IDLE with o_done=0. o_err and the counters hold.
- i_cfg_start and i_abort in the same cycle: i_cfg_start wins.
- eof and valid in the same cycle: the byte is processed first, then the eof.
- Address never wraps; the total_words check guarantees it.
- Asserting reset mid-burst returns to IDLE immediately; there is no SRAM write on the reset cycle.

Decomposition:
- Shared package uart_img_pkg: seq_state_e enum {IDLE, ARMED, COLLECT, WRITE, DONE}; channel enum {CH_R, CH_B, CH_G}; PKT_BYTES=12; PIX_PER_WORD=4.
- One sub-module, burst_pixel_packer: byte-index counter plus the three 32-bit lane registers. It outputs count_eq_12 and overflow.

Test Plan:
- Start H=1, W=4; send packet 10,30,20,11,31,21,12,32,22,13,33,23 + eof -> one write at addr 0: R=13121110, G=23222120, B=33323130; o_done=1, o_word_cnt=1.
- Start H=2, W=6 (3 words); send 3 packets -> writes at addr 0,1,2; o_done is set only after the 3rd; a 4th packet produces no write and o_err=0.
- Send an 11-byte packet + eof, then a valid packet -> o_err=1; a single write at addr 0 with the second packet's data.
- Start H=0, W=4 -> o_err=1, state IDLE, no writes, o_busy=0.
- Start H=1, W=8; after 1 word issue i_abort, then a new start H=1, W=4 -> o_err cleared, address restarts at 0.
- Assert reset during byte 6 -> all outputs 0 next sample; a following packet without cfg_start yields no write.
